// File: rtl/id_fetch_queue_if.sv
// IF -> ID fetch-queue bus: IF push lanes, ID presentation slots and ID control.
interface id_fetch_queue_if #(
   parameter int DEPTH  = 8,
   parameter int ENQ_N  = 2,
   parameter int DEQ_N  = 2,
   parameter int EXC_W  = 32,
   parameter int PRED_W = 40
);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int PNW = $clog2(DEQ_N + 1);

   // IF side
   logic [ENQ_N-1:0]             IF_Valid;
   logic [ENQ_N-1:0][31:0]       IF_Instr;
   logic [ENQ_N-1:0][31:0]       IF_PC;
   logic [ENQ_N-1:0][EXC_W-1:0]  IF_ExceptType;
   logic [ENQ_N-1:0][PRED_W-1:0] IF_PResult;
   logic                         IF_Ready;

   // ID side
   logic                         ID_Flush;
   logic [PNW-1:0]               ID_PopNum;
   logic [DEQ_N-1:0]             ID_Valid;
   logic [DEQ_N-1:0][31:0]       ID_Instr;
   logic [DEQ_N-1:0][31:0]       ID_PC;
   logic [DEQ_N-1:0][15:0]       ID_Imm16;
   logic [DEQ_N-1:0][4:0]        ID_rs;
   logic [DEQ_N-1:0][4:0]        ID_rt;
   logic [DEQ_N-1:0][4:0]        ID_rd;
   logic [DEQ_N-1:0][EXC_W-1:0]  ID_ExceptType;
   logic [DEQ_N-1:0][PRED_W-1:0] ID_PResult;
   logic [CW-1:0]                ID_Count;

   // Producer/consumer view (drives IF lanes and ID control)
   modport master (
      output IF_Valid, IF_Instr, IF_PC, IF_ExceptType, IF_PResult,
      output ID_Flush, ID_PopNum,
      input  IF_Ready, ID_Valid, ID_Instr, ID_PC, ID_Imm16, ID_rs, ID_rt, ID_rd,
      input  ID_ExceptType, ID_PResult, ID_Count
   );

   // Queue view
   modport slave (
      input  IF_Valid, IF_Instr, IF_PC, IF_ExceptType, IF_PResult,
      input  ID_Flush, ID_PopNum,
      output IF_Ready, ID_Valid, ID_Instr, ID_PC, ID_Imm16, ID_rs, ID_rt, ID_rd,
      output ID_ExceptType, ID_PResult, ID_Count
   );
endinterface

// File: rtl/id_fetch_queue.sv
// IF -> ID decoupling queue: circular buffer of DEPTH entries, up to ENQ_N
// pushes and DEQ_N presented head entries per cycle, with pre-split decode
// fields. Outputs depend only on registered state.
module id_fetch_queue #(
   parameter int DEPTH  = 8,
   parameter int ENQ_N  = 2,
   parameter int DEQ_N  = 2,
   parameter int EXC_W  = 32,
   parameter int PRED_W = 40
) (
   input logic            clk,
   input logic            rst,
   id_fetch_queue_if.slave q_if
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]     head_q, head_d;
   logic [AW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;

   logic [31:0]       mem_instr_q [DEPTH];
   logic [31:0]       mem_instr_d [DEPTH];
   logic [31:0]       mem_pc_q    [DEPTH];
   logic [31:0]       mem_pc_d    [DEPTH];
   logic [EXC_W-1:0]  mem_exc_q   [DEPTH];
   logic [EXC_W-1:0]  mem_exc_d   [DEPTH];
   logic [PRED_W-1:0] mem_pred_q  [DEPTH];
   logic [PRED_W-1:0] mem_pred_d  [DEPTH];

   logic [CW-1:0]     free_w;
   logic              if_ready;
   logic [CW-1:0]     push_n;
   logic [CW-1:0]     pop_req;
   logic [CW-1:0]     pop_p;
   logic [AW-1:0]     widx;
   logic [AW-1:0]     ridx;

   // Credit, push count and clamped pop count from registered occupancy
   always_comb begin
      free_w   = CW'(DEPTH) - count_q;
      if_ready = (free_w >= CW'(ENQ_N));
      push_n   = '0;
      if (if_ready) begin
         for (int l = 0; l < ENQ_N; l++) begin
            if (q_if.IF_Valid[l]) push_n = push_n + CW'(1);
         end
      end
      pop_req = CW'(q_if.ID_PopNum);
      pop_p   = (pop_req > count_q) ? count_q : pop_req;
   end

   // Next-state: flush clears pointers; otherwise write pushed lanes and advance both pointers
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      mem_instr_d = mem_instr_q;
      mem_pc_d    = mem_pc_q;
      mem_exc_d   = mem_exc_q;
      mem_pred_d  = mem_pred_q;
      widx        = '0;
      if (q_if.ID_Flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Lanes are contiguous from lane 0, so lane l lands at tail+l
         for (int l = 0; l < ENQ_N; l++) begin
            widx = tail_q + AW'(l);
            if (if_ready && q_if.IF_Valid[l]) begin
               mem_instr_d[widx] = q_if.IF_Instr[l];
               mem_pc_d[widx]    = q_if.IF_PC[l];
               mem_exc_d[widx]   = q_if.IF_ExceptType[l];
               mem_pred_d[widx]  = q_if.IF_PResult[l];
            end
         end
         tail_d  = tail_q + push_n[AW-1:0];
         head_d  = head_q + pop_p[AW-1:0];
         count_d = count_q + push_n - pop_p;
      end
   end

   // State registers; reset clears pointers and all stored entries
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         mem_instr_q <= '{default: '0};
         mem_pc_q    <= '{default: '0};
         mem_exc_q   <= '{default: '0};
         mem_pred_q  <= '{default: '0};
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         mem_instr_q <= mem_instr_d;
         mem_pc_q    <= mem_pc_d;
         mem_exc_q   <= mem_exc_d;
         mem_pred_q  <= mem_pred_d;
      end
   end

   // Head slots with decode split; empty slots are forced to zero
   always_comb begin
      q_if.IF_Ready      = if_ready;
      q_if.ID_Count      = count_q;
      q_if.ID_Valid      = '0;
      q_if.ID_Instr      = '0;
      q_if.ID_PC         = '0;
      q_if.ID_Imm16      = '0;
      q_if.ID_rs         = '0;
      q_if.ID_rt         = '0;
      q_if.ID_rd         = '0;
      q_if.ID_ExceptType = '0;
      q_if.ID_PResult    = '0;
      ridx               = '0;
      for (int k = 0; k < DEQ_N; k++) begin
         ridx = head_q + AW'(k);
         if (count_q > CW'(k)) begin
            q_if.ID_Valid[k]      = 1'b1;
            q_if.ID_Instr[k]      = mem_instr_q[ridx];
            q_if.ID_PC[k]         = mem_pc_q[ridx];
            q_if.ID_Imm16[k]      = mem_instr_q[ridx][15:0];
            q_if.ID_rs[k]         = mem_instr_q[ridx][25:21];
            q_if.ID_rt[k]         = mem_instr_q[ridx][20:16];
            q_if.ID_rd[k]         = mem_instr_q[ridx][15:11];
            q_if.ID_ExceptType[k] = mem_exc_q[ridx];
            q_if.ID_PResult[k]    = mem_pred_q[ridx];
         end
      end
   end
endmodule
